// File: rtl/pipe_ctrl_n.sv
// Pipeline controller: prefix stall vector from per-stage requests, and a
// registered multi-cycle flush with redirect PC for exceptions, ERET and mispredicts.
module pipe_ctrl_n #(
  parameter int unsigned STAGES       = 5,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [4:0]  ERET_CODE    = 5'h0e
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              predict_flag,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              exception_flag,
  input  logic [4:0]        exception_type,
  input  logic [ADDR_W-1:0] cp0_epc_i,
  input  logic [ADDR_W-1:0] ebase_i,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic              flush_cause,
  output logic [ADDR_W-1:0] epc_o,
  output logic              flush_to_ibuffer,
  output logic              exc_pending,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLUSH} state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t             state, state_n;
  logic               flush_n, cause_n;
  logic [ADDR_W-1:0]  epc_n, tgt_r, tgt_n, exc_target;
  logic [3:0]         fcnt, fcnt_n;
  logic               any_req;

  // A request at stage k holds every stage upstream of it as well.
  always_comb begin
    stall   = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      any_req                = any_req | stallreq_i[STAGES-1-i];
      stall[STAGES-1-i]      = any_req;
    end
    if (!rst || state == S_FLUSH) stall = '0;
  end

  assign exc_target       = (exception_type == ERET_CODE) ? cp0_epc_i : ebase_i;
  assign exc_pending      = (state == S_PEND);
  assign flush_to_ibuffer = ~rst | flush;

  always_comb begin
    state_n = state;
    flush_n = flush;
    cause_n = flush_cause;
    epc_n   = epc_o;
    fcnt_n  = fcnt;
    tgt_n   = tgt_r;
    unique case (state)
      S_IDLE: begin
        flush_n = 1'b0;
        epc_n   = '0;
        if (exception_flag && stallreq_i[STAGES-1]) begin
          // MEM is held on the dcache: park the target until it drains.
          tgt_n   = exc_target;
          cause_n = 1'b1;
          state_n = S_PEND;
        end else if (exception_flag) begin
          flush_n = 1'b1;
          cause_n = 1'b1;
          epc_n   = exc_target;
          fcnt_n  = FCNT_INIT;
          state_n = S_FLUSH;
        end else if (predict_flag) begin
          flush_n = 1'b1;
          cause_n = 1'b0;
          epc_n   = redirect_pc_i;
          fcnt_n  = FCNT_INIT;
          state_n = S_FLUSH;
        end
      end
      S_PEND: begin
        if (!stallreq_i[STAGES-1]) begin
          flush_n = 1'b1;
          epc_n   = tgt_r;
          fcnt_n  = FCNT_INIT;
          state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt == 4'd0) begin
          flush_n = 1'b0;
          epc_n   = '0;
          state_n = S_IDLE;
        end else begin
          fcnt_n = fcnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      flush        <= 1'b0;
      flush_cause  <= 1'b1;
      epc_o        <= '0;
      fcnt         <= '0;
      tgt_r        <= '0;
      stall_cycles <= '0;
    end else begin
      state       <= state_n;
      flush       <= flush_n;
      flush_cause <= cause_n;
      epc_o       <= epc_n;
      fcnt        <= fcnt_n;
      tgt_r       <= tgt_n;
      if (stall != '0 && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
